normaliser_add_pipe: RTL

//  Pipelined, handshaked post-add normaliser for the FP adder datapath; sits between mantissa adder and rounder.

---
 rtl/normaliser_add_pipe_if.sv | 34 +++
 rtl/normaliser_add_pipe.sv | 131 +++++++++++++
 2 files changed

// File: rtl/normaliser_add_pipe_if.sv
// Handshake and data bundle between mantissa adder, normaliser and rounder.
// The slave modport is the normaliser's view; master is the driver/consumer side.
interface normaliser_add_pipe_if #(
   parameter int unsigned MantWidth    = 23,
   parameter int unsigned NumRoundBits = 3,
   parameter int unsigned ExpWidth     = 8
);
   localparam int unsigned W   = MantWidth + NumRoundBits + 2;
   localparam int unsigned Ew2 = ExpWidth + 2;

   logic                  in_valid;
   logic                  in_ready;
   logic [W-1:0]          unnorm_mant;
   logic signed [Ew2-1:0] unnorm_exp;
   logic                  out_valid;
   logic                  out_ready;
   logic [W-1:0]          unrounded_mant;
   logic signed [Ew2-1:0] unrounded_exp;
   logic                  zero_flag;
   logic                  subnorm_flag;
   logic                  ovf_flag;

   modport slave (
      input  in_valid, unnorm_mant, unnorm_exp, out_ready,
      output in_ready, out_valid, unrounded_mant, unrounded_exp,
      output zero_flag, subnorm_flag, ovf_flag
   );

   modport master (
      output in_valid, unnorm_mant, unnorm_exp, out_ready,
      input  in_ready, out_valid, unrounded_mant, unrounded_exp,
      input  zero_flag, subnorm_flag, ovf_flag
   );
endinterface

// File: rtl/normaliser_add_pipe.sv
// Two-stage post-add normaliser: stage 1 captures and counts leading zeros,
// stage 2 shifts, adjusts the exponent and raises zero/subnormal/overflow flags.
module normaliser_add_pipe #(
   parameter int unsigned MantWidth    = 23,
   parameter int unsigned NumRoundBits = 3,
   parameter int unsigned ExpWidth     = 8,
   parameter int          MinExp       = -126,
   parameter int          MaxExp       = 127
) (
   input logic                  clk,
   input logic                  rst_n,
   input logic                  i_flush,
   normaliser_add_pipe_if.slave io_bus
);
   localparam int unsigned W   = MantWidth + NumRoundBits + 2;
   localparam int unsigned H   = W - 2;
   localparam int unsigned Ew2 = ExpWidth + 2;
   localparam int unsigned LzW = $clog2(H + 2);
   localparam logic signed [Ew2-1:0] MinExpV = Ew2'(MinExp);
   localparam logic signed [Ew2-1:0] MaxExpV = Ew2'(MaxExp);

   logic                  r_s1_valid, r_s2_valid;
   logic [W-1:0]          r_s1_mant;
   logic signed [Ew2-1:0] r_s1_exp;
   logic                  r_s1_carry, r_s1_norm, r_s1_zero;
   logic [LzW-1:0]        r_s1_lz;
   logic [Ew2-1:0]        r_s1_head;
   logic [W-1:0]          r_mant_o;
   logic signed [Ew2-1:0] r_exp_o;
   logic                  r_zero_o, r_sub_o, r_ovf_o;

   logic                  w_s1_load, w_s2_load;
   logic [LzW-1:0]        w_lz;
   logic [Ew2:0]          w_head_s;
   logic [Ew2-1:0]        w_head;
   logic [LzW-1:0]        w_sh;
   logic [W-1:0]          w_mant;
   logic signed [Ew2-1:0] w_exp;
   logic                  w_sub, w_ovf;

   // A stage loads when empty or when its contents move on this cycle.
   assign w_s2_load       = !r_s2_valid || io_bus.out_ready;
   assign w_s1_load       = !r_s1_valid || w_s2_load;
   assign io_bus.in_ready = w_s1_load;
   assign io_bus.out_valid = r_s2_valid;

   // Highest set bit wins since it is visited last.
   always_comb begin
      w_lz = LzW'(H + 1);
      for (int i = 0; i <= int'(H); i++) begin
         if (io_bus.unnorm_mant[i]) w_lz = LzW'(int'(H) - i);
      end
   end

   assign w_head_s = {io_bus.unnorm_exp[Ew2-1], io_bus.unnorm_exp} - {MinExpV[Ew2-1], MinExpV};
   assign w_head   = w_head_s[Ew2] ? '0 : w_head_s[Ew2-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_mant  <= '0;
         r_s1_exp   <= '0;
         r_s1_carry <= 1'b0;
         r_s1_norm  <= 1'b0;
         r_s1_zero  <= 1'b0;
         r_s1_lz    <= '0;
         r_s1_head  <= '0;
      end else begin
         if (i_flush) r_s1_valid <= 1'b0;
         else if (w_s1_load) r_s1_valid <= io_bus.in_valid;
         if (w_s1_load && io_bus.in_valid && !i_flush) begin
            r_s1_mant  <= io_bus.unnorm_mant;
            r_s1_exp   <= io_bus.unnorm_exp;
            r_s1_carry <= io_bus.unnorm_mant[W-1];
            r_s1_norm  <= io_bus.unnorm_mant[H];
            r_s1_zero  <= (io_bus.unnorm_mant == '0);
            r_s1_lz    <= w_lz;
            r_s1_head  <= w_head;
         end
      end
   end

   always_comb begin
      w_sh = r_s1_lz;
      if (r_s1_head < Ew2'(r_s1_lz)) w_sh = r_s1_head[LzW-1:0];
      w_mant = r_s1_mant;
      w_exp  = r_s1_exp;
      if (r_s1_carry) begin
         // Fold the dropped bit into the sticky position.
         w_mant = {1'b0, r_s1_mant[W-1:2], r_s1_mant[1] | r_s1_mant[0]};
         w_exp  = r_s1_exp + Ew2'(1);
      end else if (r_s1_norm) begin
         w_mant = r_s1_mant;
      end else if (r_s1_zero) begin
         w_mant = '0;
         w_exp  = MinExpV;
      end else begin
         w_mant = r_s1_mant << w_sh;
         w_exp  = r_s1_exp - Ew2'(w_sh);
      end
      w_sub = !r_s1_zero && (w_exp == MinExpV) && !w_mant[H];
      w_ovf = (w_exp > MaxExpV);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_mant_o   <= '0;
         r_exp_o    <= '0;
         r_zero_o   <= 1'b0;
         r_sub_o    <= 1'b0;
         r_ovf_o    <= 1'b0;
      end else begin
         if (i_flush) r_s2_valid <= 1'b0;
         else if (w_s2_load) r_s2_valid <= r_s1_valid;
         if (w_s2_load && r_s1_valid && !i_flush) begin
            r_mant_o <= w_mant;
            r_exp_o  <= w_exp;
            r_zero_o <= r_s1_zero;
            r_sub_o  <= w_sub;
            r_ovf_o  <= w_ovf;
         end
      end
   end

   assign io_bus.unrounded_mant = r_mant_o;
   assign io_bus.unrounded_exp  = r_exp_o;
   assign io_bus.zero_flag      = r_zero_o;
   assign io_bus.subnorm_flag   = r_sub_o;
   assign io_bus.ovf_flag       = r_ovf_o;
endmodule
